twofish_cbc_seq: RTL and testbench
==================================

TWOFISH_CBC_SEQ -- requirements
Module: twofish_cbc_seq

Interface
REQ-001 SHALL have port Clk, input, 1: single clock for the block; all state on rising edge.
REQ-002 SHALL have port Reset_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port in_data, input, 32: stream word into the sequencer.
REQ-004 SHALL have port in_valid, input, 1: in_data valid.
REQ-005 SHALL have port in_ready, output, 1: word accepted when in_valid && in_ready.
REQ-006 SHALL have port EnDe, input, 1: 1 = encrypt, 0 = decrypt; sampled with the first word of each block.
REQ-007 SHALL have port cbc, input, 1: 1 = CBC chaining, 0 = ECB; sampled with the first word of each block.
REQ-008 SHALL have port iv, input, 128: initialisation vector.
REQ-009 SHALL have port iv_load, input, 1: load iv into the chain register.
REQ-010 SHALL have port dp_block, output, 128: block presented to the cipher datapath.
REQ-011 SHALL have port dp_ende, output, 1: latched EnDe to the datapath.
REQ-012 SHALL have port dp_start, output, 1: one-cycle start pulse to the datapath.
REQ-013 SHALL have port dp_busy, input, 1: datapath busy.
REQ-014 SHALL have port dp_o, input, 128: datapath result.
REQ-015 SHALL have port out_data, output, 32: result word.
REQ-016 SHALL have port out_valid, output, 1: out_data valid.
REQ-017 SHALL have port out_ready, input, 1: word taken when out_valid && out_ready.

Function
REQ-018 SHALL implement states FILL, START, WAIT_HI, WAIT_LO, DRAIN with a 2-bit word counter.
REQ-019 FILL: in_ready=1; each accepted word shifts into a 128-bit register, first word landing in bits [127:96]; the 4th accepted word moves the FSM to START the next cycle.
REQ-020 FILL, first accepted word: SHALL latch EnDe and cbc; they are held constant until the FSM returns to FILL.
REQ-021 START: dp_start=1 for exactly one cycle; dp_block held stable from START until WAIT_LO exits; next state WAIT_HI.
REQ-022 WAIT_HI: SHALL wait for dp_busy=1, then go to WAIT_LO; WAIT_LO: SHALL wait for dp_busy=0, then capture the result and go to DRAIN.
REQ-023 Encrypt with cbc=1: dp_block = P xor chain; on capture, chain <= dp_o and result = dp_o.
REQ-024 Decrypt with cbc=1: dp_block = C; on capture, result = dp_o xor chain and chain <= C.
REQ-025 cbc=0: dp_block = input block; result = dp_o; chain unchanged.
REQ-026 DRAIN: out_valid=1 and out_data = result[127:96] first, then [95:64], [63:32], [31:0]; the word advances only on out_ready; after the 4th handshake the FSM returns to FILL with the counter at 0.
REQ-027 iv_load: SHALL load chain <= iv only in FILL with counter=0; ignored in every other state or count; takes priority over nothing else because there is no conflicting chain write in FILL.
REQ-028 in_valid during non-FILL states SHALL be ignored (in_ready=0); out_ready outside DRAIN SHALL be ignored.
REQ-029 dp_busy already 1 on entry to WAIT_HI is legal; WAIT_HI exits after one cycle.
REQ-030 No timeout; a stuck dp_busy holds WAIT_LO indefinitely.

Reset
REQ-031 Reset_n=0 SHALL asynchronously force FILL, counter=0, chain=0, block/result registers=0, dp_start=0, out_valid=0, in_ready=0 while asserted, dp_ende=0.
REQ-032 Reset mid-operation (any state) SHALL discard the partial block and result; no dp_start or out_valid pulse follows deassertion until a new 4-word block is received.
REQ-033 After deassertion, in_ready SHALL be 1 on the first Clk edge.

Verification
REQ-034 ECB encrypt with stub dp_o = dp_block xor {4{32'hA5A5A5A5}}, busy 3 cycles: words 00000001..00000004 in -> out 0x A5A5A5A4, A5A5A5A7, A5A5A5A6, A5A5A5A1.
REQ-035 CBC encrypt, iv=all 0x11 bytes, two identical zero blocks -> first dp_block = 0x1111..11; second dp_block = first dp_o.
REQ-036 CBC decrypt of the two ciphertexts from REQ-035 with the same iv -> two all-zero output blocks.
REQ-037 out_ready low for 5 cycles mid-DRAIN -> out_data held, no word lost, in_ready stays 0.
REQ-038 iv_load pulsed during WAIT_LO and at count=2 -> chain unchanged; pulsed at count=0 -> chain = iv.
REQ-039 Reset_n low in WAIT_LO -> all outputs zero immediately; next 4-word block processed with chain=0.

Source files
------------

// File: rtl/twofish_cbc_seq.sv
`default_nettype none
// ============================================================================
//  Module      : twofish_cbc_seq
//  Description : Block-mode sequencer for a Twofish cipher datapath. It packs
//                four 32-bit stream words into a 128-bit block, applies ECB or
//                CBC chaining, hands the block to the datapath, waits for the
//                busy handshake and streams the 128-bit result back out as
//                four 32-bit words.
//  Revision    : 1.0  initial release
// ============================================================================
module twofish_cbc_seq (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic [31:0]  in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         EnDe,
    input  logic         cbc,
    input  logic [127:0] iv,
    input  logic         iv_load,
    output logic [127:0] dp_block,
    output logic         dp_ende,
    output logic         dp_start,
    input  logic         dp_busy,
    input  logic [127:0] dp_o,
    output logic [31:0]  out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    typedef enum logic [2:0] {
        S_FILL    = 3'd0,
        S_START   = 3'd1,
        S_WAIT_HI = 3'd2,
        S_WAIT_LO = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    state_t         r_state;
    logic [1:0]     r_cnt;      // word counter shared by FILL and DRAIN
    logic [127:0]   r_blk;      // assembled input block (ciphertext kept for CBC decrypt)
    logic [127:0]   r_chain;    // CBC chain register
    logic [127:0]   r_result;   // output block, shifted left one word per handshake
    logic           r_cbc;      // cbc mode latched with the first word

    logic           w_in_acc;
    logic           w_out_acc;
    logic [127:0]   w_blk_next;

    assign w_in_acc   = in_valid && in_ready;
    assign w_out_acc  = out_valid && out_ready;
    assign w_blk_next = {r_blk[95:0], in_data};

    // The top word of the result register is always the word on offer.
    assign out_data = r_result[127:96];

    // Sequencer FSM; all handshake and datapath outputs are registered here.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= S_FILL;
            r_cnt     <= 2'd0;
            r_blk     <= 128'd0;
            r_chain   <= 128'd0;
            r_result  <= 128'd0;
            r_cbc     <= 1'b0;
            dp_block  <= 128'd0;
            dp_ende   <= 1'b0;
            dp_start  <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_FILL: begin
                    // in_ready is held low through reset, so it rises on the
                    // first edge after deassertion.
                    in_ready <= 1'b1;
                    if (iv_load && (r_cnt == 2'd0)) begin
                        r_chain <= iv;
                    end
                    if (w_in_acc) begin
                        r_blk <= w_blk_next;
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd0) begin
                            dp_ende <= EnDe;
                            r_cbc   <= cbc;
                        end
                        if (r_cnt == 2'd3) begin
                            // Only CBC encrypt whitens the plaintext before the cipher.
                            dp_block <= (dp_ende && r_cbc) ? (w_blk_next ^ r_chain)
                                                           : w_blk_next;
                            dp_start <= 1'b1;
                            in_ready <= 1'b0;
                            r_state  <= S_START;
                        end
                    end
                end

                S_START: begin
                    dp_start <= 1'b0;
                    r_state  <= S_WAIT_HI;
                end

                S_WAIT_HI: begin
                    if (dp_busy) begin
                        r_state <= S_WAIT_LO;
                    end
                end

                S_WAIT_LO: begin
                    if (!dp_busy) begin
                        if (r_cbc && !dp_ende) begin
                            // CBC decrypt: unwhiten with previous ciphertext,
                            // then this ciphertext becomes the new chain.
                            r_result <= dp_o ^ r_chain;
                            r_chain  <= r_blk;
                        end else begin
                            r_result <= dp_o;
                            if (r_cbc) begin
                                r_chain <= dp_o;
                            end
                        end
                        out_valid <= 1'b1;
                        r_state   <= S_DRAIN;
                    end
                end

                S_DRAIN: begin
                    if (w_out_acc) begin
                        r_result <= {r_result[95:0], 32'd0};
                        r_cnt    <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            out_valid <= 1'b0;
                            in_ready  <= 1'b1;
                            r_state   <= S_FILL;
                        end
                    end
                end

                default: begin
                    r_state <= S_FILL;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_twofish_cbc_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_twofish_cbc_seq
//  Description : Scoreboard bench for twofish_cbc_seq with a stub datapath
//                (dp_o = dp_block xor A5 pattern, busy for 3 cycles).
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_twofish_cbc_seq;

    localparam logic [127:0] KEY   = {4{32'hA5A5A5A5}};
    localparam logic [127:0] ONES11 = {16{8'h11}};
    localparam logic [127:0] B4S   = {16{8'hB4}};
    localparam logic [127:0] FFS   = {16{8'hFF}};

    logic         Clk = 1'b0;
    logic         Reset_n = 1'b0;
    logic [31:0]  in_data = 32'd0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         EnDe = 1'b0;
    logic         cbc = 1'b0;
    logic [127:0] iv = 128'd0;
    logic         iv_load = 1'b0;
    logic [127:0] dp_block;
    logic         dp_ende;
    logic         dp_start;
    logic         dp_busy = 1'b0;
    logic [127:0] dp_o = 128'd0;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready = 1'b1;

    int tests = 0;
    int fails = 0;

    logic [128:0] exp_blk_q[$];
    logic [31:0]  exp_out_q[$];

    logic [2:0]   stub_cnt = 3'd0;
    logic         stub_hold = 1'b0;

    twofish_cbc_seq dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .EnDe      (EnDe),
        .cbc       (cbc),
        .iv        (iv),
        .iv_load   (iv_load),
        .dp_block  (dp_block),
        .dp_ende   (dp_ende),
        .dp_start  (dp_start),
        .dp_busy   (dp_busy),
        .dp_o      (dp_o),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 Clk = ~Clk;

    // Stub cipher: involutive xor, busy for three cycles after start.
    always @(posedge Clk) begin
        if (dp_start) begin
            dp_busy  <= 1'b1;
            stub_cnt <= 3'd3;
            dp_o     <= dp_block ^ KEY;
        end else if (stub_cnt != 3'd0 && !stub_hold) begin
            stub_cnt <= stub_cnt - 3'd1;
            if (stub_cnt == 3'd1) dp_busy <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [128:0] act, input logic [128:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: got timeout/unexpected expected event", name);
    endtask

    // Monitor: compares datapath launches and output handshakes against the queues.
    always @(negedge Clk) begin
        if (Reset_n) begin
            if (dp_start) begin
                if (exp_blk_q.size() == 0) fail_now("dp_start_unexpected");
                else check("dp_block", {dp_ende, dp_block}, exp_blk_q.pop_front());
            end
            if (out_valid && out_ready) begin
                if (exp_out_q.size() == 0) fail_now("out_unexpected");
                else check("out_data", {97'd0, out_data}, {97'd0, exp_out_q.pop_front()});
            end
        end
    end

    task automatic push_blk(input logic e, input logic [127:0] b);
        exp_blk_q.push_back({e, b});
    endtask

    task automatic push_out(input logic [127:0] r);
        for (int k = 0; k < 4; k++) exp_out_q.push_back(r[127-32*k -: 32]);
    endtask

    task automatic wait_in_ready();
        int n = 0;
        while (!in_ready && n < 300) begin
            @(posedge Clk); #1;
            n++;
        end
        if (!in_ready) fail_now("in_ready_timeout");
    endtask

    // Sends four words; EnDe/cbc are inverted after the first word to prove latching.
    task automatic send_block(input logic [127:0] b, input logic e, input logic c,
                              input int ld_at, input logic [127:0] ivv);
        for (int i = 0; i < 4; i++) begin
            wait_in_ready();
            in_valid = 1'b1;
            in_data  = b[127-32*i -: 32];
            EnDe     = (i == 0) ? e : ~e;
            cbc      = (i == 0) ? c : ~c;
            iv_load  = (i == ld_at);
            iv       = ivv;
            @(posedge Clk); #1;
            in_valid = 1'b0;
            iv_load  = 1'b0;
        end
    endtask

    task automatic wait_drained();
        int n = 0;
        while ((exp_out_q.size() != 0 || exp_blk_q.size() != 0) && n < 400) begin
            @(posedge Clk); #1;
            n++;
        end
        if (exp_out_q.size() != 0 || exp_blk_q.size() != 0) begin
            fail_now("drain_timeout");
            exp_out_q.delete();
            exp_blk_q.delete();
        end
    endtask

    task automatic wait_busy();
        int n = 0;
        while (!dp_busy && n < 100) begin
            @(posedge Clk); #1;
            n++;
        end
        if (!dp_busy) fail_now("busy_timeout");
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"},  {128'd0, in_ready},  129'd0);
        check({tag, "_out_valid"}, {128'd0, out_valid}, 129'd0);
        check({tag, "_dp_start"},  {128'd0, dp_start},  129'd0);
        check({tag, "_dp_ende"},   {128'd0, dp_ende},   129'd0);
        check({tag, "_dp_block"},  {1'b0, dp_block},    129'd0);
        check({tag, "_out_data"},  {97'd0, out_data},   129'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and in_ready on the first edge after release.
        #2;
        check_all_zero("reset");
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        check("in_ready_before_edge", {128'd0, in_ready}, 129'd0);
        @(posedge Clk); #1;
        check("in_ready_first_edge", {128'd0, in_ready}, 129'd1);

        // ECB encrypt of words 1..4.
        push_blk(1'b1, {32'h1, 32'h2, 32'h3, 32'h4});
        push_out({32'hA5A5A5A4, 32'hA5A5A5A7, 32'hA5A5A5A6, 32'hA5A5A5A1});
        send_block({32'h1, 32'h2, 32'h3, 32'h4}, 1'b1, 1'b0, 4, 128'd0);
        wait_drained();

        // CBC encrypt, iv all 0x11, two zero blocks.
        push_blk(1'b1, ONES11);
        push_out(B4S);
        send_block(128'd0, 1'b1, 1'b1, 0, ONES11);
        push_blk(1'b1, B4S);
        push_out(ONES11);
        send_block(128'd0, 1'b1, 1'b1, 4, 128'd0);
        wait_drained();

        // CBC decrypt of those ciphertexts gives zero blocks.
        push_blk(1'b0, B4S);
        push_out(128'd0);
        send_block(B4S, 1'b0, 1'b1, 0, ONES11);
        push_blk(1'b0, ONES11);
        push_out(128'd0);
        send_block(ONES11, 1'b0, 1'b1, 4, 128'd0);
        wait_drained();

        // Output back-pressure mid-drain.
        out_ready = 1'b0;
        push_blk(1'b1, {32'h5, 32'h6, 32'h7, 32'h8});
        push_out({32'hA5A5A5A0, 32'hA5A5A5A3, 32'hA5A5A5A2, 32'hA5A5A5AD});
        send_block({32'h5, 32'h6, 32'h7, 32'h8}, 1'b1, 1'b0, 4, 128'd0);
        begin
            int n = 0;
            while (!out_valid && n < 100) begin
                @(posedge Clk); #1;
                n++;
            end
            if (!out_valid) fail_now("out_valid_timeout");
        end
        out_ready = 1'b1;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_out_data",  {97'd0, out_data},   {97'd0, 32'hA5A5A5A2});
            check("stall_out_valid", {128'd0, out_valid}, 129'd1);
            check("stall_in_ready",  {128'd0, in_ready},  129'd0);
            @(posedge Clk); #1;
        end
        out_ready = 1'b1;
        wait_drained();

        // iv_load ignored in WAIT_LO and at count 2, honoured at count 0.
        push_blk(1'b1, ONES11);
        push_out(B4S);
        send_block(128'd0, 1'b1, 1'b1, 0, ONES11);
        wait_busy();
        @(posedge Clk); #1;
        iv = FFS;
        iv_load = 1'b1;
        @(posedge Clk); #1;
        iv_load = 1'b0;
        push_blk(1'b1, B4S);
        push_out(ONES11);
        send_block(128'd0, 1'b1, 1'b1, 2, FFS);
        push_blk(1'b1, FFS);
        push_out({16{8'h5A}});
        send_block(128'd0, 1'b1, 1'b1, 0, FFS);
        wait_drained();

        // Reset while stuck in WAIT_LO, then a fresh block with chain cleared.
        stub_hold = 1'b1;
        push_blk(1'b1, ONES11);
        send_block(128'd0, 1'b1, 1'b1, 0, ONES11);
        wait_busy();
        repeat (3) @(posedge Clk);
        #1;
        Reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        stub_hold = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        @(posedge Clk); #1;
        check("in_ready_after_midreset", {128'd0, in_ready}, 129'd1);
        push_blk(1'b1, 128'd0);
        push_out(KEY);
        send_block(128'd0, 1'b1, 1'b1, 4, 128'd0);
        wait_drained();

        repeat (5) @(posedge Clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
